// File: rtl/scoreboard_reg_file_if.sv
// Register-file bus: read ports, issue request and writeback strobe of the
// pipelined CPU's ID and EX/WB stages.
interface scoreboard_reg_file_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] rr1;
   logic [ADDR_W-1:0] rr2;
   logic [WIDTH-1:0]  rd1;
   logic [WIDTH-1:0]  rd2;
   logic              busy1;
   logic              busy2;
   logic              stall;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_rd;
   logic              iss_ok;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              sb_err;

   modport master (
      output rr1, rr2, iss_en, iss_rd, wr_en, wr_addr, wr_data,
      input  rd1, rd2, busy1, busy2, stall, iss_ok, sb_err
   );

   modport slave (
      input  rr1, rr2, iss_en, iss_rd, wr_en, wr_addr, wr_data,
      output rd1, rd2, busy1, busy2, stall, iss_ok, sb_err
   );
endinterface

// File: rtl/scoreboard_reg_file.sv
// 2-read/1-write register file with a per-register pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writebacks to the read ports.
module scoreboard_reg_file #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 2,
   parameter int MAX_PEND = 3
) (
   input logic                 clk,
   input logic                 reset,
   scoreboard_reg_file_if.slave bus
);
   localparam int NREGS = 2 ** ADDR_W;
   localparam int CW    = $clog2(MAX_PEND + 1);
   localparam logic [CW-1:0] MAXP = CW'(MAX_PEND);

   logic [WIDTH-1:0] regs [NREGS];
   logic [CW-1:0]    pend [NREGS];
   logic             iss_ok;
   logic             sb_err;
   logic             busy1;
   logic             busy2;

   // A saturated register may still take an issue if a writeback retires one slot now.
   always_comb begin
      iss_ok = bus.iss_en &
               ((bus.iss_rd == '0) ||
                (pend[bus.iss_rd] < MAXP) ||
                (bus.wr_en && (bus.wr_addr == bus.iss_rd)));
   end

`ifdef RF_BYPASS_EN
   logic wr_hit1;
   logic wr_hit2;

   always_comb begin
      wr_hit1 = bus.wr_en && (bus.wr_addr == bus.rr1) && (bus.rr1 != '0);
      wr_hit2 = bus.wr_en && (bus.wr_addr == bus.rr2) && (bus.rr2 != '0);
      bus.rd1 = (bus.rr1 == '0) ? '0 : (wr_hit1 ? bus.wr_data : regs[bus.rr1]);
      bus.rd2 = (bus.rr2 == '0) ? '0 : (wr_hit2 ? bus.wr_data : regs[bus.rr2]);
      // Busy reflects the count left after this cycle's retire and re-issue.
      if (wr_hit1 && (pend[bus.rr1] != '0))
         busy1 = (pend[bus.rr1] > CW'(1)) || (iss_ok && (bus.iss_rd == bus.rr1));
      else
         busy1 = (bus.rr1 != '0) && (pend[bus.rr1] != '0);
      if (wr_hit2 && (pend[bus.rr2] != '0))
         busy2 = (pend[bus.rr2] > CW'(1)) || (iss_ok && (bus.iss_rd == bus.rr2));
      else
         busy2 = (bus.rr2 != '0) && (pend[bus.rr2] != '0);
   end
`else
   always_comb begin
      bus.rd1 = (bus.rr1 == '0) ? '0 : regs[bus.rr1];
      bus.rd2 = (bus.rr2 == '0) ? '0 : regs[bus.rr2];
      busy1   = (bus.rr1 != '0) && (pend[bus.rr1] != '0);
      busy2   = (bus.rr2 != '0) && (pend[bus.rr2] != '0);
   end
`endif

   assign bus.busy1  = busy1;
   assign bus.busy2  = busy2;
   assign bus.stall  = busy1 | busy2;
   assign bus.iss_ok = iss_ok;
   assign bus.sb_err = sb_err;

   // The pipeline commits state on the falling edge; reset wins over any traffic.
   always_ff @(negedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
            pend[r] <= '0;
         end
         sb_err <= 1'b0;
      end else begin
         if (bus.wr_en && (bus.wr_addr != '0)) begin
            regs[bus.wr_addr] <= bus.wr_data;
            if (pend[bus.wr_addr] == '0)
               sb_err <= 1'b1;
         end
         for (int r = 1; r < NREGS; r++) begin
            logic inc;
            logic dec;
            inc = iss_ok && (bus.iss_rd == ADDR_W'(r));
            dec = bus.wr_en && (bus.wr_addr == ADDR_W'(r)) && (pend[r] != '0);
            if (inc && !dec)
               pend[r] <= pend[r] + CW'(1);
            else if (dec && !inc)
               pend[r] <= pend[r] - CW'(1);
         end
      end
   end
endmodule
